mdio_responder: RTL and testbench
=================================

Name: mdio_responder

Overview:
- Clause-22 MDIO management responder (PHY side), the opposite end of the station-management master on the same MDC/MDIO pair.
- Oversamples MDC/MDIO on the system clock, decodes preamble/ST/OP/PHYAD/REGAD/TA, and serves reads from a local 16-bit register file.
- Commits writes into that file and pulses write/read strobes so surrounding logic can mirror or act on accesses.

Parameters:
- PHY_ADDR, 5'b00001, address this responder answers to.
- NUM_REGS, 8, implemented registers (addresses 0..NUM_REGS-1, 1..32).
- PREAMBLE_LEN, 32, consecutive 1 bits required before ST.
- SYNC_STAGES, 2, synchronizer depth for MDC and MDIO input.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST_N  in  1  reset, synchronous and active-low.
- MDC  in  1  management clock from master; asynchronous, each phase ≥ SYNC_STAGES+1 CLK periods.
- MDIO  inout  1  management data; driven only during read TA bit 2 and data phase, otherwise high-Z.
- WR_STB  out  1  one-CLK pulse when a write frame completes.
- WR_ADDR  out  5  REGAD of the last write; valid with WR_STB, held after.
- WR_DATA  out  16  data of the last write; valid with WR_STB, held after.
- RD_STB  out  1  one-CLK pulse when a read frame to PHY_ADDR is accepted, at TA bit 1.
- RD_ADDR  out  5  REGAD of the current read; valid with RD_STB.
- BUSY  out  1  high from ST detection until frame end or abort.

Behaviour:
- Reset (RST_N=0 at posedge CLK):
  - State S_IDLE; MDIO released (oe=0).
  - All outputs 0; all register-file entries 16'h0000; preamble and bit counters 0.
  - Reset mid-frame aborts the frame; MDIO high-Z the cycle after the reset edge.
- Sampling:
  - MDC rising edge = synchronized MDC 0→1. MDIO is sampled on that CLK cycle.
  - Output data changes on the same cycle, which satisfies the 0–300 ns clock-to-out requirement.
- Bit order: fields are MSB first.
- States and transitions, each step taken on one MDC rising edge:
  - S_IDLE: a 1 increments the preamble counter (saturates at PREAMBLE_LEN). A 0 with counter ≥ PREAMBLE_LEN → S_ST; a 0 with a short counter clears the counter.
  - S_ST: 1 → S_OP. 0 → S_IDLE with counter cleared.
  - S_OP: two bits. 10 = read, 01 = write → S_PHYAD. 00 or 11 → S_IDLE.
  - S_PHYAD: five bits. After the fifth bit, a mismatch with PHY_ADDR → S_IDLE (frame ignored, MDIO never driven); a match → S_REGAD.
  - S_REGAD: five bits → S_TA.
  - S_TA, read: bit 1 master releases; responder pulses RD_STB, latches the read word, and enables the driver with 0. Bit 2 → S_DATA, driving data[15].
  - S_TA, write: two bits, expected 10, ignored unless MDIO_TA_CHECK_EN.
  - S_DATA, read: each edge shifts out the next bit. On the edge where the master samples data[0], oe←0 → S_IDLE.
  - S_DATA, write: sample 16 bits. On the 16th bit:
    - store into the file if REGAD < NUM_REGS;
    - WR_STB pulses for any REGAD → S_IDLE.
- Read data: file[REGAD] if REGAD < NUM_REGS, else 16'h0000. Latched at TA bit 1; a same-cycle internal write is not visible.
- Preamble counter is cleared on every return to S_IDLE, so back-to-back frames need a full preamble each.
- BUSY deasserts the CLK after S_IDLE is re-entered.

Optional Feature:
- MDIO_TA_CHECK_EN defined:
  - Write TA must be 1 then 0; otherwise abort to S_IDLE with no WR_STB and no file update.
  - Read TA bit 1 is not checked.
- Undefined: TA bits are ignored for writes.

Decomposition:
- Package mdio_pkg holds:
  - state encoding (S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA);
  - OP_READ=2'b10, OP_WRITE=2'b01, ST_BIT=1'b1;
  - field widths PHYAD_W=5, REGAD_W=5, DATA_W=16.
- Sub-module mdio_sync_edge: SYNC_STAGES-deep synchronizer for MDC and MDIO, plus an MDC rising-edge pulse output aligned with the synchronized MDIO.

Test Plan:
- 32 ones, write frame PHY 1 reg 0 data 16'h0FFA, then read frame reg 0 → one WR_STB with WR_ADDR=0, WR_DATA=16'h0FFA; read returns TA bit 2 = 0 then 0000111111111010; MDIO high-Z after the last bit.
- Write PHY 2 reg 0 data 16'h1234 (PHY_ADDR=1), then read PHY 1 reg 0 → no WR_STB, MDIO never driven on the first frame; read returns 16'h0000.
- 31 ones then a read frame to PHY 1 → ignored, MDIO stays high-Z, BUSY stays 0; 32 ones then the same frame → answered.
- OP=11 after a valid preamble → abort, BUSY low by the next MDC edge; read of reg 5 after writing 16'hA5A5 → 16'hA5A5; read of reg 20 → 16'h0000, RD_STB with RD_ADDR=20.
- RST_N low for 1 CLK during read data bit 7 → MDIO high-Z next CLK; subsequent read of reg 0 returns 16'h0000.
- MDIO_TA_CHECK_EN: write with TA=11 → no WR_STB, reg unchanged; without the macro the same frame writes.

Source files
------------

// File: rtl/mdio_pkg.sv
// mdio_pkg: state encoding, opcodes and field widths shared by the MDIO responder files.
package mdio_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA} state_t;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic ST_BIT = 1'b1;
    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W = 16;
endpackage

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge: synchronizes MDC and MDIO at equal depth and flags MDC rising edges,
// so the MDIO value presented alongside the pulse is the one captured at that edge.
module mdio_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic mdc_i,
    input  logic mdio_i,
    output logic mdio_o,
    output logic mdc_rise_o
);
    logic [SYNC_STAGES-1:0] mdc_q, mdio_q;
    logic mdc_last_q;
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mdc_q <= '0;
            mdio_q <= '1;
            mdc_last_q <= 1'b0;
        end else begin
            mdc_q <= SYNC_STAGES'({mdc_q, mdc_i});
            mdio_q <= SYNC_STAGES'({mdio_q, mdio_i});
            mdc_last_q <= mdc_q[SYNC_STAGES-1];
        end
    end
    assign mdio_o = mdio_q[SYNC_STAGES-1];
    assign mdc_rise_o = mdc_q[SYNC_STAGES-1] & ~mdc_last_q;
endmodule

// File: rtl/mdio_responder.sv
// mdio_responder: Clause-22 MDIO PHY-side responder serving a local 16-bit register file.
// Build option MDIO_TA_CHECK_EN: abort write frames whose turnaround bits are not 1,0.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'b00001,
    parameter int NUM_REGS = 8,
    parameter int PREAMBLE_LEN = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               mdc_i,
    inout  wire                mdio_io,
    output logic               wr_stb_o,
    output logic [REGAD_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0]  wr_data_o,
    output logic               rd_stb_o,
    output logic [REGAD_W-1:0] rd_addr_o,
    output logic               busy_o
);
    localparam int PW = $clog2(PREAMBLE_LEN + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN);
    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [DATA_W-2:0] sh_q, sh_d;
    logic [DATA_W-1:0] sh_in, out_q, out_d, rd_word;
    logic [REGAD_W-1:0] regad_q, regad_d, wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic rd_q, rd_d, oe_q, oe_d, dout_q, dout_d;
    logic wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d, busy_q;
    logic mdio_s, rise;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    mdio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .mdc_i     (mdc_i),
        .mdio_i    (mdio_io),
        .mdio_o    (mdio_s),
        .mdc_rise_o(rise)
    );

    assign mdio_io = oe_q ? dout_q : 1'bz;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) if (regad_q == i[REGAD_W-1:0]) rd_word = regs_q[i];
    end

    // Fields arrive MSB first through sh_q; sh_in is the field including the current bit.
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        pre_d = pre_q;
        sh_in = {sh_q, mdio_s};
        sh_d = sh_q;
        out_d = out_q;
        regad_d = regad_q;
        rd_d = rd_q;
        oe_d = oe_q;
        dout_d = dout_q;
        wr_stb_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_stb_d = 1'b0;
        rd_addr_d = rd_addr_q;
        if (rise) begin
            cnt_d = cnt_q + 4'd1;
            sh_d = sh_in[DATA_W-2:0];
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    pre_d = mdio_s ? ((pre_q == PRE_MAX) ? pre_q : pre_q + 1'b1) : '0;
                    state_d = (!mdio_s && pre_q == PRE_MAX) ? S_ST : S_IDLE;
                end
                S_ST: begin
                    cnt_d = '0;
                    state_d = (mdio_s == ST_BIT) ? S_OP : S_IDLE;
                end
                S_OP: if (cnt_q == 4'd1) begin
                    cnt_d = '0;
                    rd_d = sh_in[1:0] == OP_READ;
                    state_d = (sh_in[1:0] == OP_READ || sh_in[1:0] == OP_WRITE) ? S_PHYAD : S_IDLE;
                end
                S_PHYAD: if (cnt_q == 4'(PHYAD_W - 1)) begin
                    cnt_d = '0;
                    state_d = (sh_in[PHYAD_W-1:0] == PHY_ADDR) ? S_REGAD : S_IDLE;
                end
                S_REGAD: if (cnt_q == 4'(REGAD_W - 1)) begin
                    cnt_d = '0;
                    regad_d = sh_in[REGAD_W-1:0];
                    state_d = S_TA;
                end
                S_TA: if (rd_q && cnt_q == 4'd0) begin
                    rd_stb_d = 1'b1;
                    rd_addr_d = regad_q;
                    out_d = rd_word;
                    oe_d = 1'b1;
                    dout_d = 1'b0;
                end else if (rd_q) begin
                    cnt_d = '0;
                    state_d = S_DATA;
                    dout_d = out_q[DATA_W-1];
                    out_d = out_q << 1;
                end else if (cnt_q == 4'd1) begin
                    cnt_d = '0;
`ifdef MDIO_TA_CHECK_EN
                    state_d = (sh_in[1:0] == 2'b10) ? S_DATA : S_IDLE;
`else
                    state_d = S_DATA;
`endif
                end
                S_DATA: if (rd_q) begin
                    dout_d = out_q[DATA_W-1];
                    out_d = out_q << 1;
                    oe_d = cnt_q != LAST_BIT;
                    state_d = (cnt_q == LAST_BIT) ? S_IDLE : S_DATA;
                end else if (cnt_q == LAST_BIT) begin
                    wr_stb_d = 1'b1;
                    wr_addr_d = regad_q;
                    wr_data_d = sh_in;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            pre_q <= '0;
            sh_q <= '0;
            out_q <= '0;
            regad_q <= '0;
            rd_q <= 1'b0;
            oe_q <= 1'b0;
            dout_q <= 1'b0;
            wr_stb_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_stb_q <= 1'b0;
            rd_addr_q <= '0;
            busy_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            pre_q <= pre_d;
            sh_q <= sh_d;
            out_q <= out_d;
            regad_q <= regad_d;
            rd_q <= rd_d;
            oe_q <= oe_d;
            dout_q <= dout_d;
            wr_stb_q <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_stb_q <= rd_stb_d;
            rd_addr_q <= rd_addr_d;
            busy_q <= state_q != S_IDLE;
            for (int i = 0; i < NUM_REGS; i++) if (wr_stb_d && regad_q == i[REGAD_W-1:0]) regs_q[i] <= sh_in;
        end
    end

    assign wr_stb_o = wr_stb_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign rd_stb_o = rd_stb_q;
    assign rd_addr_o = rd_addr_q;
    assign busy_o = busy_q;
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: directed MDIO master frames against mdio_responder (PHY_ADDR=1, 8 registers).
module tb_mdio_responder;
`ifdef MDIO_TA_CHECK_EN
    localparam bit TA_CHK = 1'b1;
`else
    localparam bit TA_CHK = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, mdc = 1'b0, m_oe = 1'b0, m_bit = 1'b1;
    wire mdio;
    logic wr_stb, rd_stb, busy;
    logic [4:0] wr_addr, rd_addr, rd_addr_seen = '0;
    logic [15:0] wr_data;
    int n_checks = 0, n_fails = 0, wr_cnt = 0, rd_cnt = 0, drv_cnt = 0, busy_cnt = 0;

    assign mdio = m_oe ? m_bit : 1'bz;
    pullup (mdio);
    always #5 clk = ~clk;

    mdio_responder dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .mdc_i    (mdc),
        .mdio_io  (mdio),
        .wr_stb_o (wr_stb),
        .wr_addr_o(wr_addr),
        .wr_data_o(wr_data),
        .rd_stb_o (rd_stb),
        .rd_addr_o(rd_addr),
        .busy_o   (busy)
    );

    always @(negedge clk) begin
        if (wr_stb) wr_cnt++;
        if (rd_stb) begin
            rd_cnt++;
            rd_addr_seen = rd_addr;
        end
        if (dut.oe_q) drv_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        m_oe = 1'b0;
        mdc = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One MDC period: drive (or release) MDIO while low, sample just before the rising edge.
    task automatic mdc_bit(input logic b, input logic drv, output logic smp);
        m_bit = b;
        m_oe = drv;
        repeat (7) @(negedge clk);
        smp = mdio;
        mdc = 1'b1;
        repeat (8) @(negedge clk);
        mdc = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        logic s;
        for (int i = n - 1; i >= 0; i--) mdc_bit(v[i], 1'b1, s);
    endtask

    task automatic preamble(input int n);
        logic s;
        for (int i = 0; i < n; i++) mdc_bit(1'b1, 1'b1, s);
    endtask

    task automatic write_frame(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] data,
                               input logic [1:0] ta);
        send_bits({32'd0, 2'b01, 2'b01, phy, ra, ta, data}, 32);
    endtask

    task automatic read_frame(input logic [4:0] phy, input logic [4:0] ra, input int abort_j,
                              output logic ta, output logic [15:0] d);
        logic s;
        d = '0;
        send_bits({50'd0, 2'b01, 2'b10, phy, ra}, 14);
        mdc_bit(1'b1, 1'b0, s);
        mdc_bit(1'b1, 1'b0, ta);
        for (int j = 15; j >= 0; j--) begin
            if (j == abort_j) begin
                m_oe = 1'b0;
                repeat (7) @(negedge clk);
                d[j] = mdio;
                check("abort_oe_before", dut.oe_q, 1);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check("abort_oe_after", dut.oe_q, 0);
                return;
            end
            mdc_bit(1'b1, 1'b0, d[j]);
        end
    endtask

    initial begin
        logic ta;
        logic [15:0] d;
        int w0, r0, v0, b0;
        do_reset();
        check("rst_wr_stb", wr_stb, 0);
        check("rst_rd_stb", rd_stb, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_oe", dut.oe_q, 0);

        w0 = wr_cnt;
        preamble(32);
        write_frame(5'd1, 5'd0, 16'h0FFA, 2'b10);
        check("t1_wr_cnt", wr_cnt - w0, 1);
        check("t1_wr_addr", wr_addr, 0);
        check("t1_wr_data", wr_data, 16'h0FFA);
        r0 = rd_cnt;
        preamble(32);
        read_frame(5'd1, 5'd0, -1, ta, d);
        check("t1_ta", ta, 0);
        check("t1_rd_data", d, 16'h0FFA);
        check("t1_rd_cnt", rd_cnt - r0, 1);
        check("t1_rd_addr", rd_addr_seen, 0);
        check("t1_release_oe", dut.oe_q, 0);
        check("t1_release_line", mdio, 1);

        do_reset();
        w0 = wr_cnt;
        v0 = drv_cnt;
        preamble(32);
        write_frame(5'd2, 5'd0, 16'h1234, 2'b10);
        check("t2_wr_cnt", wr_cnt - w0, 0);
        check("t2_drv", drv_cnt - v0, 0);
        preamble(32);
        read_frame(5'd1, 5'd0, -1, ta, d);
        check("t2_ta", ta, 0);
        check("t2_rd_data", d, 16'h0000);

        do_reset();
        preamble(32);
        write_frame(5'd1, 5'd3, 16'hBEEF, 2'b10);
        r0 = rd_cnt;
        v0 = drv_cnt;
        b0 = busy_cnt;
        preamble(31);
        read_frame(5'd1, 5'd3, -1, ta, d);
        check("t3_short_rd_cnt", rd_cnt - r0, 0);
        check("t3_short_drv", drv_cnt - v0, 0);
        check("t3_short_busy", busy_cnt - b0, 0);
        r0 = rd_cnt;
        preamble(32);
        read_frame(5'd1, 5'd3, -1, ta, d);
        check("t3_rd_data", d, 16'hBEEF);
        check("t3_rd_cnt", rd_cnt - r0, 1);

        preamble(32);
        b0 = busy_cnt;
        send_bits(64'b0111, 4);
        check("t4_busy_seen", busy_cnt > b0, 1);
        check("t4_busy_low", busy, 0);
        preamble(32);
        write_frame(5'd1, 5'd5, 16'hA5A5, 2'b10);
        preamble(32);
        read_frame(5'd1, 5'd5, -1, ta, d);
        check("t4_reg5", d, 16'hA5A5);
        w0 = wr_cnt;
        preamble(32);
        write_frame(5'd1, 5'd20, 16'hFFFF, 2'b10);
        check("t4_wr20_cnt", wr_cnt - w0, 1);
        check("t4_wr20_addr", wr_addr, 20);
        r0 = rd_cnt;
        preamble(32);
        read_frame(5'd1, 5'd20, -1, ta, d);
        check("t4_reg20", d, 16'h0000);
        check("t4_rd20_addr", rd_addr_seen, 20);
        check("t4_rd20_cnt", rd_cnt - r0, 1);

        do_reset();
        preamble(32);
        write_frame(5'd1, 5'd0, 16'hFF00, 2'b10);
        preamble(32);
        read_frame(5'd1, 5'd0, 7, ta, d);
        check("t5_partial", d[15:7], 9'b111111110);
        preamble(32);
        read_frame(5'd1, 5'd0, -1, ta, d);
        check("t5_after_rst", d, 16'h0000);

        w0 = wr_cnt;
        preamble(32);
        write_frame(5'd1, 5'd1, 16'h1111, 2'b11);
        check("t6_wr_cnt", wr_cnt - w0, TA_CHK ? 0 : 1);
        preamble(32);
        read_frame(5'd1, 5'd1, -1, ta, d);
        check("t6_reg1", d, TA_CHK ? 16'h0000 : 16'h1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
